// File: rtl/mod_mul_arbiter.sv
// Round-robin front end that shares one modular multiplier between four
// requesters. Each accepted operand pair is issued once, the result (or a
// timeout abort) is held for the granted requester until it is taken.
module mod_mul_arbiter #(
    parameter int TIMEOUT = 4096
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    req_valid,
    input  logic [1023:0] req_a,
    input  logic [1023:0] req_b,
    output logic [3:0]    req_ready,
    output logic [3:0]    rsp_valid,
    input  logic [3:0]    rsp_ready,
    output logic [255:0]  rsp_data,
    output logic          rsp_err,
    output logic          mm_start,
    output logic [255:0]  mm_a,
    output logic [255:0]  mm_b,
    input  logic [255:0]  mm_result,
    input  logic          mm_done,
    output logic          mm_rst,
    output logic          busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    // Last WAIT cycle index before the operation is abandoned.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_t         state_reg;
    state_t         state_next;
    logic [1:0]     rr_ptr_reg;
    logic [1:0]     gnt_reg;
    logic [15:0]    wait_cnt_reg;
    logic [3:0]     rsp_valid_reg;
    logic           rsp_err_reg;
    logic [255:0]   rsp_data_reg;
    logic           mm_start_reg;
    logic [255:0]   mm_a_reg;
    logic [255:0]   mm_b_reg;
    logic           tmo_pulse_reg;

    logic [255:0]   a_slice [4];
    logic [255:0]   b_slice [4];

    logic           win_valid;
    logic [1:0]     win_idx;
    logic [1:0]     scan_idx;

    logic           accept;
    logic           done_take;
    logic           tmo_take;
    logic           resp_take;

    // Unpack the per-requester operand slices.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_slice
            assign a_slice[gi] = req_a[256*gi +: 256];
            assign b_slice[gi] = req_b[256*gi +: 256];
        end
    endgenerate

    // Round-robin pick: the requester closest to rr_ptr (inclusive) wins;
    // scanning from the farthest offset lets the nearest one overwrite.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = rr_ptr_reg;
        scan_idx  = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            scan_idx = rr_ptr_reg + 2'(k);
            if (req_valid[scan_idx]) begin
                win_valid = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode plus the per-state strobes that drive the datapath.
    always_comb begin
        state_next = state_reg;
        req_ready  = 4'b0000;
        accept     = 1'b0;
        done_take  = 1'b0;
        tmo_take   = 1'b0;
        resp_take  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (win_valid) begin
                    req_ready  = 4'b0001 << win_idx;
                    accept     = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                // A done arriving on the last allowed cycle still counts.
                if (mm_done) begin
                    done_take  = 1'b1;
                    state_next = ST_RESP;
                end else if (wait_cnt_reg == WAIT_LAST) begin
                    tmo_take   = 1'b1;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready[gnt_reg]) begin
                    resp_take  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath: operand capture, start pulse, wait counter, response hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_reg    <= 2'd0;
            gnt_reg       <= 2'd0;
            wait_cnt_reg  <= 16'd0;
            rsp_valid_reg <= 4'b0000;
            rsp_err_reg   <= 1'b0;
            rsp_data_reg  <= 256'd0;
            mm_start_reg  <= 1'b0;
            mm_a_reg      <= 256'd0;
            mm_b_reg      <= 256'd0;
            tmo_pulse_reg <= 1'b0;
        end else begin
            // High during ISSUE only, since accept happens only in IDLE.
            mm_start_reg  <= accept;
            tmo_pulse_reg <= tmo_take;

            if (accept) begin
                mm_a_reg <= a_slice[win_idx];
                mm_b_reg <= b_slice[win_idx];
                gnt_reg  <= win_idx;
            end

            if (state_reg == ST_ISSUE) begin
                wait_cnt_reg <= 16'd0;
            end else if (state_reg == ST_WAIT && !mm_done) begin
                wait_cnt_reg <= wait_cnt_reg + 16'd1;
            end

            if (done_take) begin
                rsp_data_reg  <= mm_result;
                rsp_err_reg   <= 1'b0;
                rsp_valid_reg <= 4'b0001 << gnt_reg;
            end else if (tmo_take) begin
                rsp_data_reg  <= 256'd0;
                rsp_err_reg   <= 1'b1;
                rsp_valid_reg <= 4'b0001 << gnt_reg;
            end

            if (resp_take) begin
                rsp_valid_reg <= 4'b0000;
                rr_ptr_reg    <= gnt_reg + 2'd1;
            end
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_err   = rsp_err_reg;
    assign rsp_data  = rsp_data_reg;
    assign mm_start  = mm_start_reg;
    assign mm_a      = mm_a_reg;
    assign mm_b      = mm_b_reg;
    // Multiplier is held in reset with us, and kicked once after an abort.
    assign mm_rst    = rst | tmo_pulse_reg;
    assign busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_mod_mul_arbiter.sv
// Bench for mod_mul_arbiter: a behavioural modular multiplier with a
// programmable latency, a table of directed transactions, hand-written
// timeout and reset sequences, and randomized round-robin traffic.
module tb_mod_mul_arbiter;

    localparam logic [255:0] P = 256'h7fffffffffffffffffffffffffffffffffffffffffffffffffffffffffffffed;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    req_valid;
    logic [1023:0] req_a;
    logic [1023:0] req_b;
    logic [3:0]    req_ready;
    logic [3:0]    rsp_valid;
    logic [3:0]    rsp_ready;
    logic [255:0]  rsp_data;
    logic          rsp_err;
    logic          mm_start;
    logic [255:0]  mm_a;
    logic [255:0]  mm_b;
    logic [255:0]  mm_result;
    logic          mm_done;
    logic          mm_rst;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int model_ptr = 0;
    int start_cnt = 0;

    // Multiplier model controls.
    int   lat_cfg = 2;
    bit   never_done = 1'b0;
    logic mdl_done = 1'b0;
    logic mdl_run = 1'b0;
    int   mdl_cnt = 0;
    logic [255:0] mdl_res = '0;

    mod_mul_arbiter #(.TIMEOUT(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .mm_start  (mm_start),
        .mm_a      (mm_a),
        .mm_b      (mm_b),
        .mm_result (mm_result),
        .mm_done   (mm_done),
        .mm_rst    (mm_rst),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] mulmod(input logic [255:0] a, input logic [255:0] b);
        logic [511:0] p;
        p = {256'd0, a} * {256'd0, b};
        p = p % {256'd0, P};
        return p[255:0];
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int w = 0; w < 8; w++) r[32*w +: 32] = $urandom();
        return r;
    endfunction

    // First requester with a valid request, scanning from ptr modulo 4.
    function automatic int model_winner(input logic [3:0] m, input int ptr);
        for (int k = 0; k < 4; k++) begin
            if (m[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return 0;
    endfunction

    // Multiplier: done rises lat_cfg cycles after the start cycle, drops on
    // start, and stays high afterwards until the next start or mm_rst.
    always @(posedge clk or posedge mm_rst) begin
        if (mm_rst) begin
            mdl_done <= 1'b0;
            mdl_run  <= 1'b0;
            mdl_cnt  <= 0;
        end else if (mm_start) begin
            mdl_res <= mulmod(mm_a, mm_b);
            if (never_done) begin
                mdl_done <= 1'b0;
                mdl_run  <= 1'b0;
            end else if (lat_cfg <= 1) begin
                mdl_done <= 1'b1;
                mdl_run  <= 1'b0;
            end else begin
                mdl_done <= 1'b0;
                mdl_run  <= 1'b1;
                mdl_cnt  <= lat_cfg - 1;
            end
        end else if (mdl_run) begin
            if (mdl_cnt == 1) begin
                mdl_done <= 1'b1;
                mdl_run  <= 1'b0;
            end else begin
                mdl_cnt <= mdl_cnt - 1;
            end
        end
    end

    assign mm_done   = mdl_done;
    assign mm_result = mdl_res;

    always @(posedge clk) begin
        if (mm_start === 1'b1) start_cnt <= start_cnt + 1;
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction: accept, issue, wait, response hold, release.
    task automatic run_row(input logic [3:0] mask, input logic [1023:0] a_all,
                           input logic [1023:0] b_all, input int lat, input int hold,
                           input bit noise, input int exp_gnt, input logic [255:0] exp_data);
        logic [3:0] oh;
        int cyc;
        int starts0;
        oh = 4'(1 << exp_gnt);
        lat_cfg   = lat;
        req_valid = mask;
        req_a     = a_all;
        req_b     = b_all;
        rsp_ready = (hold > 0) ? ~oh : 4'hF;
        starts0   = start_cnt;
        #1;
        chk("idle_busy", 256'(busy), 256'(0));
        chk("req_ready", 256'(req_ready), 256'(oh));
        step();
        chk("mm_start", 256'(mm_start), 256'(1));
        chk("mm_a", mm_a, a_all[256*exp_gnt +: 256]);
        chk("mm_b", mm_b, b_all[256*exp_gnt +: 256]);
        chk("issue_req_ready", 256'(req_ready), 256'(0));
        cyc = 0;
        do begin
            if (noise) req_valid = 4'($urandom_range(0, 15));
            step();
            cyc++;
        end while (rsp_valid == 4'b0000 && cyc < 40);
        chk("rsp_latency", 256'(cyc), 256'(lat + 1));
        chk("rsp_valid", 256'(rsp_valid), 256'(oh));
        chk("rsp_data", rsp_data, exp_data);
        chk("rsp_err", 256'(rsp_err), 256'(0));
        chk("mm_rst_quiet", 256'(mm_rst), 256'(0));
        chk("start_pulses", 256'(start_cnt - starts0), 256'(1));
        $display("txn mask=%b gnt=%0d lat=%0d hold=%0d data=%0h err=%0b cycles=%0d",
                 mask, exp_gnt, lat, hold, rsp_data, rsp_err, cyc);
        for (int h = 0; h < hold; h++) begin
            if (noise) rsp_ready = 4'($urandom_range(0, 15)) & ~oh;
            #1;
            chk("hold_valid", 256'(rsp_valid), 256'(oh));
            chk("hold_data", rsp_data, exp_data);
            chk("hold_req_ready", 256'(req_ready), 256'(0));
            step();
        end
        rsp_ready = 4'hF;
        step();
        chk("rsp_clear", 256'(rsp_valid), 256'(0));
        chk("back_idle", 256'(busy), 256'(0));
        model_ptr = (exp_gnt + 1) % 4;
    endtask

    typedef struct {
        logic [3:0]   mask;
        logic [255:0] a;
        logic [255:0] b;
        int           lat;
        int           hold;
        int           gnt;
        logic [255:0] data;
    } vec_t;

    vec_t vecs [11];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        logic [1023:0] a_all;
        logic [1023:0] b_all;
        logic [3:0]    mask;
        int            g;

        // Round robin with all four held, then directed cases.
        vecs[0]  = '{4'b1111, P - 1, P - 1, 3, 0, 0, 256'd1};
        vecs[1]  = '{4'b1111, P - 1, P - 1, 3, 0, 1, 256'd1};
        vecs[2]  = '{4'b1111, P - 1, P - 1, 3, 0, 2, 256'd1};
        vecs[3]  = '{4'b1111, P - 1, P - 1, 3, 0, 3, 256'd1};
        vecs[4]  = '{4'b1111, P - 1, P - 1, 3, 0, 0, 256'd1};
        vecs[5]  = '{4'b0001, 256'd3, 256'd5, 1, 0, 0, 256'd15};
        // Stale done with result 15 is still high when this one issues.
        vecs[6]  = '{4'b0001, 256'd7, 256'd11, 4, 0, 0, 256'd77};
        vecs[7]  = '{4'b0100, 256'd20, 256'd30, 2, 10, 2, 256'd600};
        // Done lands on the final allowed WAIT cycle: must not be an abort.
        vecs[8]  = '{4'b0110, 256'd100, 256'd200, 8, 0, 1, 256'd20000};
        vecs[9]  = '{4'b1001, 256'd9, 256'd13, 5, 1, 3, 256'd117};
        vecs[10] = '{4'b0011, 256'd2, 256'd255, 7, 2, 0, 256'd510};

        rst = 1'b1;
        req_valid = 4'b0000;
        req_a = '0;
        req_b = '0;
        rsp_ready = 4'b0000;
        step();
        step();
        chk("rst_rsp_valid", 256'(rsp_valid), 256'(0));
        chk("rst_rsp_data", rsp_data, 256'd0);
        chk("rst_rsp_err", 256'(rsp_err), 256'(0));
        chk("rst_mm_start", 256'(mm_start), 256'(0));
        chk("rst_mm_a", mm_a, 256'd0);
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_mm_rst", 256'(mm_rst), 256'(1));
        chk("rst_req_ready", 256'(req_ready), 256'(0));
        rst = 1'b0;
        #1;
        chk("run_mm_rst", 256'(mm_rst), 256'(0));
        model_ptr = 0;

        for (int i = 0; i < 11; i++) begin
            run_row(vecs[i].mask, {4{vecs[i].a}}, {4{vecs[i].b}}, vecs[i].lat,
                    vecs[i].hold, 1'b0, vecs[i].gnt, vecs[i].data);
        end

        // Timeout abort with the multiplier never finishing.
        never_done = 1'b1;
        req_valid = 4'b0001;
        req_a = {4{256'd5}};
        req_b = {4{256'd6}};
        rsp_ready = 4'b0000;
        #1;
        chk("tmo_req_ready", 256'(req_ready), 256'(1));
        step();
        chk("tmo_mm_start", 256'(mm_start), 256'(1));
        for (int k = 1; k <= 9; k++) begin
            step();
            if (k < 9) begin
                chk("tmo_early_mm_rst", 256'(mm_rst), 256'(0));
                chk("tmo_early_valid", 256'(rsp_valid), 256'(0));
            end
        end
        chk("tmo_mm_rst", 256'(mm_rst), 256'(1));
        chk("tmo_valid", 256'(rsp_valid), 256'(1));
        chk("tmo_err", 256'(rsp_err), 256'(1));
        chk("tmo_data", rsp_data, 256'd0);
        $display("txn timeout gnt=0 data=%0h err=%0b", rsp_data, rsp_err);
        step();
        chk("tmo_pulse_end", 256'(mm_rst), 256'(0));
        chk("tmo_hold_valid", 256'(rsp_valid), 256'(1));
        rsp_ready = 4'b0001;
        step();
        chk("tmo_clear", 256'(rsp_valid), 256'(0));
        never_done = 1'b0;
        model_ptr = 1;

        // Randomized traffic against the round-robin reference.
        for (int t = 0; t < 25; t++) begin
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < 4; i++) begin
                a_all[256*i +: 256] = rand256();
                b_all[256*i +: 256] = rand256();
            end
            g = model_winner(mask, model_ptr);
            run_row(mask, a_all, b_all, int'($urandom_range(1, 7)), int'($urandom_range(0, 3)),
                    1'b1, g, mulmod(a_all[256*g +: 256], b_all[256*g +: 256]));
        end

        // Reset in the middle of WAIT.
        run_row(4'b0100, {4{256'd9}}, {4{256'd9}}, 3, 0, 1'b0, 2, 256'd81);
        never_done = 1'b1;
        req_valid = 4'b0100;
        rsp_ready = 4'hF;
        step();
        step();
        step();
        chk("pre_rst_busy", 256'(busy), 256'(1));
        rst = 1'b1;
        #1;
        chk("arst_busy", 256'(busy), 256'(0));
        chk("arst_rsp_valid", 256'(rsp_valid), 256'(0));
        chk("arst_rsp_data", rsp_data, 256'd0);
        chk("arst_rsp_err", 256'(rsp_err), 256'(0));
        chk("arst_mm_start", 256'(mm_start), 256'(0));
        chk("arst_mm_a", mm_a, 256'd0);
        chk("arst_mm_b", mm_b, 256'd0);
        chk("arst_mm_rst", 256'(mm_rst), 256'(1));
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rst_hold_mm_rst", 256'(mm_rst), 256'(1));
            chk("rst_hold_valid", 256'(rsp_valid), 256'(0));
        end
        req_valid = 4'b0000;
        never_done = 1'b0;
        rst = 1'b0;
        model_ptr = 0;
        $display("txn reset during wait");
        run_row(4'b1111, {4{P - 1}}, {4{P - 1}}, 3, 0, 1'b0, 0, 256'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
